sp_instr_ram_arbiter: RTL and testbench



---
 rtl/sp_instr_ram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sp_instr_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_instr_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_instr_ram_arbiter
//
// Shares one single-port instruction RAM between the core fetch port and the
// system-bus/loader port. At most one access is granted per cycle. The grant
// is combinational. The granted port's request is driven straight onto the RAM
// pins. Read data comes back one cycle later with a valid pulse that is
// steered to the port that issued the access.
//
// Arbitration: fetch has fixed priority. A saturating wait counter tracks how
// long the bus has been stalled. Once the counter reaches MAX_WAIT, the bus
// wins outright. With MAX_WAIT = 0 the bus always wins.
//
// Optional feature macro: INSTR_RAM_WRITE_LOCK_EN
//   When defined, lock_i blocks bus writes. A blocked write is still granted,
//   but it is kept off the RAM pins. Its response carries b_err_o = 1.
//   When undefined, lock_i and b_err_o do not exist.
//
// Parameters
//   ADDR_WIDTH  byte address width of the RAM
//   DATA_WIDTH  data width (byte enables are DATA_WIDTH/8)
//   MAX_WAIT    stalled bus cycles before the bus is forced to win
//
// Ports
//   clk, rstn_i                       clock, asynchronous active-low reset
//   f_req_i, f_addr_i                 fetch read request
//   f_gnt_o, f_rvalid_o, f_rdata_o    fetch grant / response
//   b_req_i, b_we_i, b_be_i,
//   b_addr_i, b_wdata_i               bus request (read or write)
//   b_gnt_o, b_rvalid_o, b_rdata_o    bus grant / response
//   ram_en_o, ram_addr_o, ram_wdata_o,
//   ram_we_o, ram_be_o, ram_rdata_i   RAM wrapper side
//   lock_i, b_err_o                   write lock / rejected-write flag
//                                     (only with INSTR_RAM_WRITE_LOCK_EN)
// ---------------------------------------------------------------------------
module sp_instr_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    // fetch port
    input  logic                    f_req_i,
    input  logic [ADDR_WIDTH-1:0]   f_addr_i,
    output logic                    f_gnt_o,
    output logic                    f_rvalid_o,
    output logic [DATA_WIDTH-1:0]   f_rdata_o,
    // bus / loader port
    input  logic                    b_req_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic                    b_gnt_o,
    output logic                    b_rvalid_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    // RAM wrapper
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`ifdef INSTR_RAM_WRITE_LOCK_EN
    ,
    input  logic                    lock_i,
    output logic                    b_err_o
`endif
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    // A zero-width counter is illegal. For MAX_WAIT = 0, a single bit that
    // saturates immediately at zero behaves as the constant-zero counter.
    localparam int CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_BUS   = 2'd2
    } resp_t;

    resp_t                 resp_reg, resp_next;
    logic [CNT_WIDTH-1:0]  wait_cnt_reg, wait_cnt_next;
    logic                  bus_force;
    logic                  f_gnt, b_gnt;
    logic                  write_blocked;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    // The bus overrides fetch once it has waited long enough. Otherwise fetch
    // has priority, and the bus takes any cycle that fetch leaves idle.
    assign bus_force = b_req_i && (wait_cnt_reg == WAIT_LIMIT);
    assign f_gnt     = f_req_i && !bus_force;
    assign b_gnt     = b_req_i && !f_gnt;

    assign f_gnt_o = f_gnt;
    assign b_gnt_o = b_gnt;

`ifdef INSTR_RAM_WRITE_LOCK_EN
    // A locked write is acknowledged but never touches the array.
    assign write_blocked = b_gnt && b_we_i && lock_i;
`else
    assign write_blocked = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // RAM drive
    // -----------------------------------------------------------------------
    assign ram_en_o    = (f_gnt || b_gnt) && !write_blocked;
    assign ram_we_o    = b_gnt && b_we_i && !write_blocked;
    assign ram_addr_o  = b_gnt ? b_addr_i : f_addr_i;
    // Write data only matters on bus writes, so no mux is needed.
    assign ram_wdata_o = b_wdata_i;

    // Fetch accesses always read the full word.
    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_be_lane
            assign ram_be_o[gi] = b_gnt ? b_be_i[gi] : 1'b1;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Bus wait counter
    // -----------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (b_gnt) begin
            wait_cnt_next = '0;
        end else if (b_req_i && (wait_cnt_reg != WAIT_LIMIT)) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Response FSM
    // -----------------------------------------------------------------------
    // This FSM records which port owns the data arriving from the RAM in the
    // next cycle. Reset drops any in-flight response.
    always_comb begin
        resp_next = RESP_IDLE;
        if (f_gnt) begin
            resp_next = RESP_FETCH;
        end else if (b_gnt) begin
            resp_next = RESP_BUS;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_reg <= RESP_IDLE;
        end else begin
            resp_reg <= resp_next;
        end
    end

    assign f_rvalid_o = (resp_reg == RESP_FETCH);
    assign b_rvalid_o = (resp_reg == RESP_BUS);
    assign f_rdata_o  = ram_rdata_i;
    assign b_rdata_o  = ram_rdata_i;

`ifdef INSTR_RAM_WRITE_LOCK_EN
    // -----------------------------------------------------------------------
    // Rejected-write flag
    // -----------------------------------------------------------------------
    // This flag is registered alongside the response state, so it lines up
    // with b_rvalid_o.
    logic b_err_reg, b_err_next;

    always_comb begin
        b_err_next = write_blocked;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            b_err_reg <= 1'b0;
        end else begin
            b_err_reg <= b_err_next;
        end
    end

    assign b_err_o = b_err_reg;
`endif

    // -----------------------------------------------------------------------
    // Sanity check: the two grants are mutually exclusive by construction.
    // -----------------------------------------------------------------------
    a_one_grant : assert property (@(posedge clk) disable iff (!rstn_i)
                                   !(f_gnt && b_gnt));

endmodule

// File: tb/tb_sp_instr_ram_arbiter.sv
module tb_sp_instr_ram_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rstn;
    // main DUT (MAX_WAIT = 4)
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          b_req, b_we;
    logic [BW-1:0] b_be;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [BW-1:0] ram_be;
    logic          lock;
    logic          b_err;

    // second DUT (MAX_WAIT = 0), grant behaviour only
    logic          f_req0, b_req0;
    logic          f_gnt0, f_rvalid0, b_gnt0, b_rvalid0;
    logic [DW-1:0] f_rdata0, b_rdata0, ram_wdata0;
    logic          ram_en0, ram_we0;
    logic [AW-1:0] ram_addr0;
    logic [BW-1:0] ram_be0;
    logic [DW-1:0] ram_rdata0;
    logic          b_err0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        bit          is_bus;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] mem [0:(1 << (AW - 2)) - 1];

    sp_instr_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) u_dut (
        .clk(clk), .rstn_i(rstn),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
        .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
        .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
        .b_rdata_o(b_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
`ifdef INSTR_RAM_WRITE_LOCK_EN
        , .lock_i(lock), .b_err_o(b_err)
`endif
    );

    sp_instr_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(0)) u_dut0 (
        .clk(clk), .rstn_i(rstn),
        .f_req_i(f_req0), .f_addr_i(15'h0010), .f_gnt_o(f_gnt0),
        .f_rvalid_o(f_rvalid0), .f_rdata_o(f_rdata0),
        .b_req_i(b_req0), .b_we_i(1'b0), .b_be_i(4'hF), .b_addr_i(15'h0020),
        .b_wdata_i(32'h0), .b_gnt_o(b_gnt0), .b_rvalid_o(b_rvalid0),
        .b_rdata_o(b_rdata0),
        .ram_en_o(ram_en0), .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata0),
        .ram_we_o(ram_we0), .ram_be_o(ram_be0), .ram_rdata_i(ram_rdata0)
`ifdef INSTR_RAM_WRITE_LOCK_EN
        , .lock_i(1'b0), .b_err_o(b_err0)
`endif
    );

`ifndef INSTR_RAM_WRITE_LOCK_EN
    assign b_err  = 1'b0;
    assign b_err0 = 1'b0;
`endif

    assign ram_rdata0 = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with registered read
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int i = 0; i < BW; i++) begin
                    if (ram_be[i]) mem[ram_addr[AW-1:2]][i*8 +: 8] <= ram_wdata[i*8 +: 8];
                end
            end
            ram_rdata <= mem[ram_addr[AW-1:2]];
        end
    end

    // Monitor: pops one expected response per observed rvalid
    always @(negedge clk) begin
        if (f_rvalid || b_rvalid) begin
            n_cmp++;
            if (f_rvalid && b_rvalid) begin
                n_bad++;
                $display("FAIL both_rvalid cyc=%0d: got f=1 b=1 expected one", cyc);
            end else if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
                n_bad++;
                $display("FAIL unexpected_rvalid cyc=%0d: got f=%0b b=%0b expected none",
                         cyc, f_rvalid, b_rvalid);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_bus != b_rvalid) begin
                    n_bad++;
                    $display("FAIL resp_port cyc=%0d: got bus=%0b expected bus=%0b",
                             cyc, b_rvalid, mon_e.is_bus);
                end else if (mon_e.chk_data &&
                             ((mon_e.is_bus ? b_rdata : f_rdata) !== mon_e.data)) begin
                    n_bad++;
                    $display("FAIL resp_data cyc=%0d: got %08h expected %08h", cyc,
                             mon_e.is_bus ? b_rdata : f_rdata, mon_e.data);
`ifdef INSTR_RAM_WRITE_LOCK_EN
                end else if (mon_e.is_bus && (b_err !== mon_e.err)) begin
                    n_bad++;
                    $display("FAIL resp_err cyc=%0d: got %0b expected %0b", cyc, b_err, mon_e.err);
`endif
                end else begin
                    $display("resp cyc=%0d port=%s data=%08h", cyc,
                             mon_e.is_bus ? "bus" : "fetch", mon_e.is_bus ? b_rdata : f_rdata);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_rvalid cyc=%0d: got none expected %s response",
                     cyc, mon_e.is_bus ? "bus" : "fetch");
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input bit is_bus, input bit cd, input logic [31:0] d, input bit err);
        exp_t x;
        x.due      = cyc + 1;
        x.is_bus   = is_bus;
        x.chk_data = cd;
        x.data     = d;
        x.err      = err;
        sb_q.push_back(x);
    endtask

    // Drives one cycle of requests shortly after the rising edge.
    // The task returns at the falling edge, where the combinational grants are checked.
    task automatic step(input bit fr, input logic [AW-1:0] fa, input bit br, input bit bw,
                        input logic [BW-1:0] be, input logic [AW-1:0] ba,
                        input logic [DW-1:0] wd, input bit lk);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa;
        b_req = br; b_we = bw; b_be = be; b_addr = ba; b_wdata = wd;
        lock = lk;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, '0, '0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        bit         exp_b;

        for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = 32'h0;
        mem[0]    = 32'h11111111;
        mem[1]    = 32'h22222222;
        mem[2]    = 32'h33333333;
        mem[16'h40] = 32'h01234567;   // byte 0x100
        mem[16'h80] = 32'h89ABCDEF;   // byte 0x200

        rstn = 1'b0;
        f_req = 0; f_addr = '0; b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
        lock = 0; f_req0 = 0; b_req0 = 0;

        // Reset state
        @(negedge clk);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_b_err", b_err, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_grants", {f_gnt, b_gnt}, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // Fetch only, back-to-back
        step(1, 15'h0000, 0, 0, '0, '0, '0, 0);
        chk("fetch0_gnt", {f_gnt, b_gnt}, 2'b10);
        chk("fetch0_ram", {ram_en, ram_we, ram_be, ram_addr}, {1'b1, 1'b0, 4'hF, 15'h0000});
        push(0, 1, 32'h11111111, 0);
        step(1, 15'h0004, 0, 0, '0, '0, '0, 0);
        chk("fetch1_gnt", {f_gnt, b_gnt}, 2'b10);
        push(0, 1, 32'h22222222, 0);
        step(1, 15'h0008, 0, 0, '0, '0, '0, 0);
        chk("fetch2_gnt", {f_gnt, b_gnt}, 2'b10);
        chk("fetch2_addr", ram_addr, 15'h0008);
        push(0, 1, 32'h33333333, 0);
        idle();

        // Partial bus write, then read back
        step(0, '0, 1, 1, 4'b0011, 15'h0100, 32'hDEADBEEF, 0);
        chk("bwr_gnt", {f_gnt, b_gnt}, 2'b01);
        chk("bwr_ram", {ram_en, ram_we, ram_be, ram_addr}, {1'b1, 1'b1, 4'b0011, 15'h0100});
        chk("bwr_wdata", ram_wdata, 32'hDEADBEEF);
        push(1, 0, 32'h0, 0);
        step(0, '0, 1, 0, 4'hF, 15'h0100, '0, 0);
        chk("brd_gnt", {f_gnt, b_gnt, ram_we}, 3'b010);
        push(1, 1, 32'h0123BEEF, 0);
        idle();

`ifdef INSTR_RAM_WRITE_LOCK_EN
        // Locked write is acknowledged with an error and leaves memory intact
        step(0, '0, 1, 1, 4'hF, 15'h0200, 32'h12345678, 1);
        chk("lock_gnt", b_gnt, 1);
        chk("lock_ram", {ram_en, ram_we}, 2'b00);
        push(1, 0, 32'h0, 1);
        step(0, '0, 1, 0, 4'hF, 15'h0200, '0, 1);
        chk("lock_rd_ram_en", ram_en, 1);
        push(1, 1, 32'h89ABCDEF, 0);
        idle();
`endif

        // Continuous fetch plus bus: the bus is forced through at cycles 4 and 9.
        for (int k = 0; k < 10; k++) begin
            step(1, 15'h0000, 1, 0, 4'hF, 15'h0008, '0, 0);
            exp_b = (k == 4) || (k == 9);
            chk($sformatf("arb%0d_gnt", k), {f_gnt, b_gnt}, {~exp_b, exp_b});
            if (exp_b) push(1, 1, 32'h33333333, 0);
            else       push(0, 1, 32'h11111111, 0);
        end
        idle();

        // MAX_WAIT = 0: the bus wins every cycle in which it requests.
        pat = 8'b1011_0010;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            f_req0 = 1'b1;
            b_req0 = pat[k];
            @(negedge clk);
            chk($sformatf("mw0_%0d_gnt", k), {f_gnt0, b_gnt0}, {~pat[k], pat[k]});
        end
        @(posedge clk); #1 f_req0 = 0; b_req0 = 0;

        // Reset mid-access: the grant in T is dropped by a reset in T+1.
        step(1, 15'h0004, 0, 0, '0, '0, '0, 0);
        chk("rstmid_gnt", f_gnt, 1);
        @(posedge clk);
        #1;
        f_req = 0;
        rstn = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid_in", {f_rvalid, b_rvalid}, 2'b00);
        @(posedge clk); #1 rstn = 1'b1;
        idle();
        chk("rstmid_rvalid_after", {f_rvalid, b_rvalid}, 2'b00);
        idle();

        // Flush any leftover expected responses
        repeat (3) @(negedge clk);
        while (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_resp: got none expected %s response due %0d",
                     mon_e.is_bus ? "bus" : "fetch", mon_e.due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
